// File: rtl/pano_pins_bringup.sv
// Pano Logic bring-up top: WM8750 codec init over open-drain I2C, IDT clock activity detect, LEDs.
// The I2C init sequencer is built only when PANO_CODEC_INIT_EN is defined; otherwise the bus floats.
module pano_pins_bringup #(
  parameter int I2C_QDIV = 63,
  parameter int HB_BITS  = 24
) (
  input  logic osc_clk,
  input  logic reset_n,
  input  logic idt_clk1,
  inout  wire  audio_sclk,
  inout  wire  audio_sdin,
  output logic led_green,
  output logic led_blue,
  output logic led_red
);

  logic [HB_BITS-1:0] hb_q, hb_d;
  logic [2:0]         idt_sync_q, idt_sync_d;
  logic               idt_alive_q, idt_alive_d;

  // idt_sync_q[1] is the synchronized level, idt_sync_q[2] its previous value
  always_comb begin
    hb_d        = hb_q + HB_BITS'(1);
    idt_sync_d  = {idt_sync_q[1:0], idt_clk1};
    idt_alive_d = idt_alive_q | (idt_sync_q[2] ^ idt_sync_q[1]);
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_q        <= '0;
      idt_sync_q  <= '0;
      idt_alive_q <= 1'b0;
    end else begin
      hb_q        <= hb_d;
      idt_sync_q  <= idt_sync_d;
      idt_alive_q <= idt_alive_d;
    end
  end

`ifdef PANO_CODEC_INIT_EN
  localparam int QW = $clog2(I2C_QDIV);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_BIT, ST_ACK, ST_STOP, ST_GAP, ST_DONE, ST_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          qtick;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [1:0]    entry_q, entry_d;
  logic          err_q, err_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          sda_s1_q, sda_s2_q;
  logic [7:0]    tx_byte;

  function automatic logic [7:0] init_byte(input logic [1:0] entry, input logic [1:0] idx);
    logic [15:0] word;
    case (entry)
      2'd0:    word = 16'h1E00;
      2'd1:    word = 16'h32C0;
      2'd2:    word = 16'h35F8;
      default: word = 16'h0E02;
    endcase
    case (idx)
      2'd0:    init_byte = 8'h34;
      2'd1:    init_byte = word[15:8];
      default: init_byte = word[7:0];
    endcase
  endfunction

  assign qtick = (qcnt_q == QW'(I2C_QDIV - 1));

  // ph counts quarters inside the current state; IDLE lasts two quarters after reset
  always_comb begin
    qcnt_d  = qtick ? '0 : qcnt_q + QW'(1);
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    entry_d = entry_q;
    err_d   = err_q;
    if (qtick) begin
      ph_d = ph_q + 2'd1;
      unique case (state_q)
        ST_IDLE:  if (ph_q == 2'd1) begin
                    state_d = ST_START;
                    ph_d    = '0;
                  end
        ST_START: if (ph_q == 2'd1) begin
                    state_d = ST_BIT;
                    ph_d    = '0;
                    bit_d   = 3'd7;
                    byte_d  = '0;
                  end
        ST_BIT:   if (ph_q == 2'd3) begin
                    if (bit_q == 3'd0) state_d = ST_ACK;
                    else               bit_d   = bit_q - 3'd1;
                  end
        ST_ACK: begin
          if (ph_q == 2'd2 && sda_s2_q) err_d = 1'b1;
          if (ph_q == 2'd3) begin
            if (err_q || byte_q == 2'd2) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_BIT;
              bit_d   = 3'd7;
              byte_d  = byte_q + 2'd1;
            end
          end
        end
        ST_STOP:  if (ph_q == 2'd2) begin
                    ph_d    = '0;
                    state_d = err_q ? ST_ERROR : ST_GAP;
                  end
        ST_GAP:   if (ph_q == 2'd3) begin
                    if (entry_q == 2'd3) begin
                      state_d = ST_DONE;
                    end else begin
                      state_d = ST_START;
                      entry_d = entry_q + 2'd1;
                    end
                  end
        default:  ph_d = ph_q;
      endcase
    end
  end

  // Pin enables are decoded from the next state so they switch on the same edge as the state
  always_comb begin
    tx_byte  = init_byte(entry_d, byte_d);
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      ST_START: begin
        sda_oe_d = 1'b1;
        scl_oe_d = (ph_d == 2'd1);
      end
      ST_BIT: begin
        scl_oe_d = ~ph_d[1];
        sda_oe_d = ~tx_byte[bit_d];
      end
      ST_ACK:   scl_oe_d = ~ph_d[1];
      ST_STOP: begin
        scl_oe_d = (ph_d == 2'd0);
        sda_oe_d = (ph_d != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      qcnt_q   <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      entry_q  <= '0;
      err_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      sda_s1_q <= 1'b0;
      sda_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      entry_q  <= entry_d;
      err_q    <= err_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      sda_s1_q <= audio_sdin;
      sda_s2_q <= sda_s1_q;
    end
  end

  assign audio_sclk = scl_oe_q ? 1'b0 : 1'bz;
  assign audio_sdin = sda_oe_q ? 1'b0 : 1'bz;
  assign led_blue   = (state_q == ST_DONE);
  assign led_red    = err_q;
`else
  assign audio_sclk = 1'bz;
  assign audio_sdin = 1'bz;
  assign led_blue   = 1'b0;
  assign led_red    = 1'b0;
`endif

  assign led_green = hb_q[HB_BITS-1] | (led_blue & idt_alive_q);

endmodule

// File: tb/tb_pano_pins_bringup.sv
// Self-checking bench for pano_pins_bringup: I2C bus monitor/slave model, event-level reference model.
module tb_pano_pins_bringup;
  localparam int QDIV = 63;
  localparam int HBW  = 10;
  localparam int WRQ  = 117;

  logic osc_clk  = 1'b0;
  logic reset_n  = 1'b0;
  logic idt_clk1 = 1'b0;
  logic idt_run  = 1'b0;
  logic slv_low  = 1'b0;
  wire  audio_sclk, audio_sdin;
  logic led_green, led_blue, led_red;

  pullup (audio_sclk);
  pullup (audio_sdin);
  assign audio_sdin = slv_low ? 1'b0 : 1'bz;

  pano_pins_bringup #(.I2C_QDIV(QDIV), .HB_BITS(HBW)) dut (
    .osc_clk(osc_clk), .reset_n(reset_n), .idt_clk1(idt_clk1),
    .audio_sclk(audio_sclk), .audio_sdin(audio_sdin),
    .led_green(led_green), .led_blue(led_blue), .led_red(led_red));

  initial forever #10 osc_clk = ~osc_clk;

  // 250 MHz relative to the 100 MHz clock; edges never coincide with a rising clock edge
  initial forever begin
    #4;
    if (idt_run) idt_clk1 = ~idt_clk1;
    else         idt_clk1 = 1'b0;
  end

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int ev_q[$], exp_q[$];
  int hi126 = 0, lo126 = 0, scl_rises = 0, sda_edges = 0, acked = 0, ack_limit = 0, nacks = 0;
  int tbl [12] = '{'h34, 'h1E, 'h00, 'h34, 'h32, 'hC0, 'h34, 'h35, 'hF8, 'h34, 'h0E, 'h02};

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge osc_clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic hb_msb(input int c);
    return (c % (1 << HBW)) >= (1 << (HBW - 1));
  endfunction

  // Expected bus transcript when the slave acknowledges only the first L bytes
  task automatic build_exp(input int L);
    int  acks;
    bit  halt;
    acks = 0;
    halt = 0;
    exp_q.delete();
    for (int e = 0; e < 4 && !halt; e++) begin
      exp_q.push_back(-1);
      for (int j = 0; j < 3; j++) begin
        exp_q.push_back(tbl[e*3+j]);
        if (acks < L) acks++;
        else begin
          halt = 1;
          break;
        end
      end
      exp_q.push_back(-2);
    end
  endtask

  task automatic chk_events(input string tag);
    chk({tag, "_len"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), (i < ev_q.size()) ? ev_q[i] : -99, exp_q[i]);
  endtask

  task automatic clear_logs();
    ev_q.delete();
    hi126 = 0; lo126 = 0; scl_rises = 0; sda_edges = 0; acked = 0; nacks = 0;
  endtask

  // Bus monitor and acknowledging slave, sampled on the falling clock edge
  initial begin
    logic scl_p, sda_p, scl_n, sda_n, in_frame;
    logic [8:0] sh;
    int seg, nbit;
    scl_p = 1; sda_p = 1; in_frame = 0; sh = '0; seg = 0; nbit = 0;
    forever begin
      @(negedge osc_clk);
      scl_n = audio_sclk;
      sda_n = audio_sdin;
      if (!reset_n) begin
        in_frame = 0; nbit = 0; seg = 0; slv_low = 0; scl_p = 1; sda_p = 1;
      end else begin
        if (sda_n != sda_p) sda_edges++;
        if (scl_p && scl_n && sda_p && !sda_n) begin
          ev_q.push_back(-1);
          in_frame = 1;
          nbit = 0;
        end
        if (scl_p && scl_n && !sda_p && sda_n) begin
          ev_q.push_back(-2);
          in_frame = 0;
        end
        if (scl_n != scl_p) begin
          if (seg == 2*QDIV) begin
            if (scl_p) hi126++;
            else       lo126++;
          end
          seg = 1;
        end else seg++;
        if (!scl_p && scl_n) begin
          scl_rises++;
          if (in_frame) begin
            sh = {sh[7:0], sda_n};
            nbit++;
            if (nbit == 9) begin
              ev_q.push_back(int'(sh[8:1]));
              if (sh[0]) nacks++;
              nbit = 0;
            end
          end
        end
        if (scl_p && !scl_n) begin
          if (in_frame && nbit == 8 && acked < ack_limit) begin
            slv_low = 1;
            acked++;
          end else slv_low = 0;
        end
        scl_p = scl_n;
        sda_p = sda_n;
      end
    end
  end

  initial begin
    int t, target, L, r;
    tick(5);
    chk("rst_scl_z", audio_sclk, 1);
    chk("rst_sda_z", audio_sdin, 1);
    chk("rst_green", led_green, 0);
    chk("rst_blue", led_blue, 0);
    chk("rst_red", led_red, 0);
    chk("rst_idt_alive", dut.idt_alive_q, 0);

`ifdef PANO_CODEC_INIT_EN
    // Full sequence with a reset pulse during the second write
    clear_logs();
    ack_limit = 99;
    reset_n = 1;
    cyc = 0;
    while (audio_sdin === 1'b1 && cyc < 400) tick(1);
    chk("first_start_cyc", cyc, 2*QDIV);
    for (int k = 0; k < 4; k++) begin
      tick($urandom_range(100, 800));
      chk($sformatf("hb%0d", k), led_green, hb_msb(cyc));
    end
    target = (2 + WRQ) * QDIV + $urandom_range(50, WRQ*QDIV - 400);
    tick(target - cyc);
    t = 0;
    while (audio_sclk === 1'b1 && audio_sdin === 1'b1 && t < 300) begin
      tick(1);
      t++;
    end
    chk("bus_busy_before_rst", (audio_sclk === 1'b0) || (audio_sdin === 1'b0), 1);
    reset_n = 0;
    #1;
    chk("midrst_scl_z", audio_sclk, 1);
    chk("midrst_sda_z", audio_sdin, 1);
    build_exp(99);
    for (int i = 0; i < 5; i++)
      chk($sformatf("write0_ev%0d", i), (i < ev_q.size()) ? ev_q[i] : -99, exp_q[i]);
    tick(3);
    clear_logs();
    reset_n = 1;
    cyc = 0;
    while (led_blue !== 1'b1 && cyc < 31000) tick(1);
    chk("done_cyc", cyc, (2 + 4*WRQ) * QDIV);
    chk("done_red", led_red, 0);
    chk_events("full");
    chk("scl_high_126", hi126, 4*27);
    chk("scl_low_126", lo126, 4*26);
    chk("full_nacks", nacks, 0);

    // IDT activity shows on led_green once initialization is done
    tick(((1 << HBW) - (cyc % (1 << HBW))) % (1 << HBW));
    chk("idt_quiet_green", led_green, 0);
    chk("idt_quiet_alive", dut.idt_alive_q, 0);
    idt_run = 1;
    tick(4);
    chk("idt_alive", dut.idt_alive_q, 1);
    chk("idt_green", led_green, 1);
    idt_run = 0;

    // No slave: first byte is NACKed
    reset_n = 0;
    tick(3);
    chk("rst_clears_alive", dut.idt_alive_q, 0);
    clear_logs();
    ack_limit = 0;
    reset_n = 1;
    cyc = 0;
    while (led_red !== 1'b1 && cyc < 4000) tick(1);
    chk("nack_cyc", cyc, (2 + 2 + 35) * QDIV);
    tick(400);
    chk("nack_blue", led_blue, 0);
    build_exp(0);
    chk_events("nack");
    chk("nack_count", nacks, 1);
    r = scl_rises;
    tick(3000);
    chk("nack_quiet_scl", scl_rises, r);
    chk("nack_scl_z", audio_sclk, 1);
    chk("nack_sda_z", audio_sdin, 1);
    chk("nack_red_sticky", led_red, 1);

    // NACK inside the last entry takes priority over DONE
    reset_n = 0;
    tick(3);
    clear_logs();
    L = 9 + $urandom_range(0, 2);
    ack_limit = L;
    reset_n = 1;
    cyc = 0;
    while (led_red !== 1'b1 && cyc < 31000) tick(1);
    chk("late_nack_cyc", cyc, (2 + (L/3)*WRQ + 2 + (L%3)*36 + 35) * QDIV);
    tick(400);
    chk("late_nack_blue", led_blue, 0);
    chk("late_nack_red", led_red, 1);
    build_exp(L);
    chk_events("late_nack");
`else
    clear_logs();
    reset_n = 1;
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      tick($urandom_range(500, 3000));
      chk($sformatf("hb%0d", k), led_green, hb_msb(cyc));
    end
    tick(50000 - cyc);
    chk("off_scl_edges", scl_rises, 0);
    chk("off_sda_edges", sda_edges, 0);
    chk("off_scl_z", audio_sclk, 1);
    chk("off_sda_z", audio_sdin, 1);
    chk("off_blue", led_blue, 0);
    chk("off_red", led_red, 0);
    tick(((1 << HBW) - (cyc % (1 << HBW))) % (1 << HBW));
    chk("idt_quiet_alive", dut.idt_alive_q, 0);
    idt_run = 1;
    tick(4);
    chk("idt_alive", dut.idt_alive_q, 1);
    chk("off_green_hb_only", led_green, 0);
    idt_run = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
